// File: rtl/alu_nzcv_reg_if.sv
// Operation/result bus for alu_nzcv_reg: issue handshake, operands, flag load port,
// result handshake and flag outputs.
interface alu_nzcv_reg_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic [2:0]   i_alu_ctrl;
  logic         i_set_flags;
  logic         i_flag_wr;
  logic [3:0]   i_flag_data;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic [3:0]   o_res_nzcv;
  logic [3:0]   o_nzcv;

  modport slave (
    input  i_valid, i_a, i_b, i_alu_ctrl, i_set_flags, i_flag_wr, i_flag_data, i_ready,
    output o_ready, o_valid, o_result, o_res_nzcv, o_nzcv
  );

  modport master (
    output i_valid, i_a, i_b, i_alu_ctrl, i_set_flags, i_flag_wr, i_flag_data, i_ready,
    input  o_ready, o_valid, o_result, o_res_nzcv, o_nzcv
  );
endinterface

// File: rtl/alu_nzcv_reg.sv
// Registered ALU with architectural NZCV flag register, carry-in ops and a
// one-deep valid/ready result register.
module alu_nzcv_reg #(
  parameter int N = 32
) (
  input logic            i_clk,
  input logic            i_rst_n,
  alu_nzcv_reg_if.slave  bus
);

  logic         valid_q, valid_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   res_nzcv_q, res_nzcv_d;
  logic [3:0]   nzcv_q, nzcv_d;

  logic         accept;
  logic         is_arith;
  logic         cin;
  logic [N-1:0] b_op;
  logic [N:0]   sum;
  logic [N-1:0] logic_res;
  logic [N-1:0] calc_res;
  logic [3:0]   calc_nzcv;

  function automatic logic [3:0] logic_flags(input logic [N-1:0] r);
    return {r[N-1], (r == '0), 2'b00};
  endfunction

  function automatic logic [3:0] arith_flags(input logic [N-1:0] a, input logic [N-1:0] bp,
                                              input logic [N:0] s);
    return {s[N-1], (s[N-1:0] == '0), s[N],
            (a[N-1] == bp[N-1]) && (s[N-1] != a[N-1])};
  endfunction

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // Arithmetic opcodes have ctrl[1]=0; ctrl[0] selects subtract, ctrl[2] selects carry-in from C.
  assign is_arith = !bus.i_alu_ctrl[1];
  assign b_op     = bus.i_alu_ctrl[0] ? ~bus.i_b : bus.i_b;
  assign cin      = bus.i_alu_ctrl[2] ? nzcv_q[1] : bus.i_alu_ctrl[0];
  assign sum      = {1'b0, bus.i_a} + {1'b0, b_op} + {{N{1'b0}}, cin};

  always_comb begin
    logic_res = '0;
    case (bus.i_alu_ctrl)
      3'b010:  logic_res = bus.i_a & bus.i_b;
      3'b011:  logic_res = bus.i_a | bus.i_b;
      3'b110:  logic_res = bus.i_a ^ bus.i_b;
      3'b111:  logic_res = bus.i_a & ~bus.i_b;
      default: logic_res = '0;
    endcase
  end

  assign calc_res  = is_arith ? sum[N-1:0] : logic_res;
  assign calc_nzcv = is_arith ? arith_flags(bus.i_a, b_op, sum) : logic_flags(logic_res);

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    res_nzcv_d = res_nzcv_q;
    nzcv_d     = nzcv_q;
    if (accept) begin
      valid_d    = 1'b1;
      result_d   = calc_res;
      res_nzcv_d = calc_nzcv;
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
    // Direct load outranks flags from a concurrently accepted op.
    if (bus.i_flag_wr) begin
      nzcv_d = bus.i_flag_data;
    end else if (accept && bus.i_set_flags) begin
      nzcv_d = calc_nzcv;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      res_nzcv_q <= 4'b0000;
      nzcv_q     <= 4'b0000;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      res_nzcv_q <= res_nzcv_d;
      nzcv_q     <= nzcv_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_result   = result_q;
  assign bus.o_res_nzcv = res_nzcv_q;
  assign bus.o_nzcv     = nzcv_q;

endmodule

// File: tb/tb_alu_nzcv_reg.sv
// Directed bench for alu_nzcv_reg: vector table plus stall, flag-load and async reset sequences.
module tb_alu_nzcv_reg;

  localparam int N = 32;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_ADC = 3'b100, OP_SBC = 3'b101, OP_XOR = 3'b110, OP_BIC = 3'b111;

  typedef struct {
    logic [2:0]   op;
    logic         sf;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [3:0]   rnzcv;
    logic [3:0]   nzcv;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[16];

  alu_nzcv_reg_if #(.N(N)) bus ();

  alu_nzcv_reg #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] op, input logic sf,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    bus.i_valid     = vld;
    bus.i_alu_ctrl  = op;
    bus.i_set_flags = sf;
    bus.i_a         = a;
    bus.i_b         = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_ADD, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0110, 4'b0110};
    vecs[1]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 4'b0110};
    vecs[2]  = '{OP_ADC, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 4'b0000, 4'b0000};
    vecs[3]  = '{OP_SUB, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 4'b0011};
    vecs[4]  = '{OP_AND, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 4'b0011};
    vecs[5]  = '{OP_SBC, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0010, 4'b0010};
    vecs[6]  = '{OP_SBC, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000, 4'b1000};
    vecs[7]  = '{OP_SBC, 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 4'b0010, 4'b0010};
    vecs[8]  = '{OP_OR,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 4'b0010};
    vecs[9]  = '{OP_XOR, 1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000, 4'b0000};
    vecs[10] = '{OP_BIC, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 4'b1000, 4'b1000};
    vecs[11] = '{OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 4'b1001};
    vecs[12] = '{OP_ADC, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 4'b1000};
    vecs[13] = '{OP_SUB, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0110, 4'b0110};
    vecs[14] = '{OP_ADC, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0110, 4'b0110};
    vecs[15] = '{OP_AND, 1'b1, 32'h0000_FFFF, 32'h0000_FF00, 32'h0000_FF00, 4'b0000, 4'b0000};

    rst_n           = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_flag_wr   = 1'b0;
    bus.i_flag_data = 4'b0000;
    drive(1'b0, OP_ADD, 1'b0, '0, '0);
    #12;
    chk("reset o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("reset o_result", bus.o_result, 32'd0);
    chk("reset o_res_nzcv", {28'b0, bus.o_res_nzcv}, 32'd0);
    chk("reset o_nzcv", {28'b0, bus.o_nzcv}, 32'd0);
    chk("reset o_ready", {31'b0, bus.o_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table ops at one per cycle with i_ready held high.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].sf, vecs[i].a, vecs[i].b);
      tick();
      chk($sformatf("vec%0d o_valid", i), {31'b0, bus.o_valid}, 32'd1);
      chk($sformatf("vec%0d o_result", i), bus.o_result, vecs[i].res);
      chk($sformatf("vec%0d o_res_nzcv", i), {28'b0, bus.o_res_nzcv}, {28'b0, vecs[i].rnzcv});
      chk($sformatf("vec%0d o_nzcv", i), {28'b0, bus.o_nzcv}, {28'b0, vecs[i].nzcv});
    end
    @(negedge clk);
    drive(1'b0, OP_ADD, 1'b0, '0, '0);
    tick();
    chk("drain o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("drain o_result hold", bus.o_result, 32'h0000_FF00);

    // Downstream stall: first result held, second op blocked until i_ready rises.
    @(negedge clk);
    bus.i_ready = 1'b0;
    drive(1'b1, OP_SUB, 1'b1, 32'd3, 32'd5);
    tick();
    chk("stall first o_result", bus.o_result, 32'hFFFF_FFFE);
    chk("stall first o_nzcv", {28'b0, bus.o_nzcv}, 32'b1000);
    @(negedge clk);
    drive(1'b1, OP_ADD, 1'b1, 32'd1, 32'd1);
    #1;
    chk("stall o_ready low", {31'b0, bus.o_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall held o_valid", {31'b0, bus.o_valid}, 32'd1);
      chk("stall held o_result", bus.o_result, 32'hFFFF_FFFE);
      chk("stall held o_res_nzcv", {28'b0, bus.o_res_nzcv}, 32'b1000);
      chk("stall held o_nzcv", {28'b0, bus.o_nzcv}, 32'b1000);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    #1;
    chk("unstall o_ready", {31'b0, bus.o_ready}, 32'd1);
    tick();
    chk("second o_result", bus.o_result, 32'd2);
    chk("second o_nzcv", {28'b0, bus.o_nzcv}, 32'b0000);
    @(negedge clk);
    drive(1'b0, OP_ADD, 1'b0, '0, '0);
    tick();
    chk("second drained", {31'b0, bus.o_valid}, 32'd0);

    // Direct flag load beats a flag-setting op on the same edge.
    @(negedge clk);
    bus.i_flag_wr   = 1'b1;
    bus.i_flag_data = 4'b1001;
    drive(1'b1, OP_SUB, 1'b1, 32'd0, 32'd0);
    tick();
    chk("flagwr o_nzcv", {28'b0, bus.o_nzcv}, 32'b1001);
    chk("flagwr o_result", bus.o_result, 32'd0);
    chk("flagwr o_res_nzcv", {28'b0, bus.o_res_nzcv}, 32'b0110);
    @(negedge clk);
    bus.i_flag_data = 4'b0101;
    drive(1'b0, OP_ADD, 1'b0, '0, '0);
    tick();
    chk("flagwr idle o_nzcv", {28'b0, bus.o_nzcv}, 32'b0101);
    @(negedge clk);
    bus.i_flag_wr = 1'b0;

    // Asynchronous reset with a live result and set flags.
    drive(1'b1, OP_ADD, 1'b1, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("pre-rst o_nzcv", {28'b0, bus.o_nzcv}, 32'b0110);
    chk("pre-rst o_valid", {31'b0, bus.o_valid}, 32'd1);
    @(negedge clk);
    drive(1'b1, OP_ADD, 1'b1, 32'd7, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst o_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("async rst o_result", bus.o_result, 32'd0);
    chk("async rst o_nzcv", {28'b0, bus.o_nzcv}, 32'd0);
    chk("async rst o_res_nzcv", {28'b0, bus.o_res_nzcv}, 32'd0);
    tick();
    chk("rst held o_valid", {31'b0, bus.o_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst o_result", bus.o_result, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nzcv_reg.md
Name: alu_nzcv_reg

Overview:
- Registered, parametrised successor to the combinational NZCV ALU.
- Adds an architectural NZCV flag register, carry-in ops (ADC/SBC), XOR/BIC, a per-op flag-set enable and a valid/ready output handshake.
- Sits between the decode stage and the writeback/branch logic; the branch logic reads the flag register.

Parameters:
- N, 32, datapath width in bits (N >= 2).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operation presented.
- o_ready  out  1  block can accept an operation this cycle.
- i_a  in  N  operand A.
- i_b  in  N  operand B.
- i_alu_ctrl  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADC, 101 SBC, 110 XOR, 111 BIC.
- i_set_flags  in  1  accepted op writes its flags into the flag register.
- i_flag_wr  in  1  direct load of the flag register.
- i_flag_data  in  4  value for direct load {N,Z,C,V}.
- o_valid  out  1  result register holds an unconsumed result.
- i_ready  in  1  downstream consumes the result.
- o_result  out  N  registered result.
- o_res_nzcv  out  4  flags computed for o_result, independent of i_set_flags.
- o_nzcv  out  4  architectural flag register {N,Z,C,V}.

Behaviour:
- Reset (i_rst_n low, async): o_valid=0, o_result=0, o_res_nzcv=0, o_nzcv=0. Reset mid-operation discards the held result; no flag write survives.
- o_ready = !o_valid || i_ready (combinational). Accept = i_valid && o_ready.
- On accept: o_result/o_res_nzcv load the computed values and o_valid=1 next cycle. Latency is 1 cycle.
- Else if o_valid && i_ready: o_valid=0 and o_result holds its last value.
- Back-to-back ops sustain 1 op/cycle while i_ready=1. With i_ready=0 and o_valid=1, o_ready=0 and held outputs stay stable.
- Arithmetic is computed at N+1 bits.
  - ADD: a+b.
  - SUB: a+~b+1.
  - ADC: a+b+C.
  - SBC: a+~b+C, where C is the current o_nzcv C bit before this edge.
- Flag N = result[N-1]; Z = (result==0).
- Arith ops: C = bit N of the sum (for SUB/SBC, C=1 means no borrow); V = (a[N-1]==b'[N-1]) && (res[N-1]!=a[N-1]), where b' is b or ~b.
- Logic ops (AND, OR, XOR, BIC=a&~b): C=0, V=0.
- Flag register update at an edge, in priority order:
  1. i_flag_wr=1 loads i_flag_data, even if an accepted op has i_set_flags=1.
  2. Otherwise, accept && i_set_flags loads the computed flags.
  3. Otherwise, hold.
- i_flag_wr acts regardless of i_valid/o_ready.
- Carry chain: an ADC/SBC accepted on the cycle after a flag-setting op uses that op's C, since the flag register updates at the same edge.
- Stalled ops: an op not accepted (o_ready=0) has no effect on flags or result.
- Wrap-around: results are modulo 2^N. No saturation.

Test Plan:
- Reset then ADD, set_flags=1, a=0x0000_0001, b=0xFFFF_FFFF → next cycle o_valid=1, o_result=0x0000_0000, o_nzcv=4'b0110.
- ADD set_flags a=0xFFFF_FFFF, b=0x0000_0001, then ADC set_flags a=0, b=0 on the next cycle → results 0x0, then 0x1; o_nzcv 0110, then 0000.
- SUB set_flags a=0x8000_0000, b=1 → o_result=0x7FFF_FFFF, o_nzcv=4'b0011. A following AND with set_flags=0, a=b=0xFFFF_FFFF → o_res_nzcv=1000 and o_nzcv stays 0011.
- i_ready=0 with two ops presented → first held stable, o_ready=0, second not accepted and flags unchanged. Raise i_ready → second accepted on that cycle, appears on the next.
- Simultaneous i_flag_wr=1, i_flag_data=4'b1001 and accepted SUB set_flags 0-0 → o_nzcv=1001 and o_result=0x0.
- Assert i_rst_n low mid-stream with o_valid=1 and o_nzcv=0110 → immediately o_valid=0, o_result=0, o_nzcv=0000 without waiting for a clock edge.
